// File: rtl/axis_out_stream_buffer_pkg.sv
// Shared defaults and helpers for the AXI4-Stream output buffer.
// Entries carry {last, data}, so they are one bit wider than the stream data.
package axis_out_stream_buffer_pkg;

  localparam int unsigned DEF_TDATA_WIDTH = 32'd32;
  localparam int unsigned DEF_FIFO_DEPTH  = 32'd16;
  localparam int unsigned DEF_CNT_WIDTH   = 32'd16;
  localparam int unsigned DEF_ENTRY_WIDTH = DEF_TDATA_WIDTH + 32'd1;

  // Ceiling log2; clogb2(1) is 0.
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned r;
    r = 32'd0;
    for (int unsigned i = 32'd0; i < 32'd32; i++) begin
      if ((32'd1 << i) < value) begin
        r = i + 32'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_out_stream_buffer_stream_fifo_fwft.sv
// First-word-fall-through FIFO with a registered head entry.
// Full and empty are decoded from the occupancy count, not from pointer compare.
module stream_fifo_fwft
  import axis_out_stream_buffer_pkg::*;
#(
  parameter  int unsigned ENTRY_W = DEF_ENTRY_WIDTH,
  parameter  int unsigned DEPTH   = DEF_FIFO_DEPTH,
  localparam int unsigned PTR_W   = clogb2(DEPTH),
  localparam int unsigned LVL_W   = PTR_W + 32'd1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [ENTRY_W-1:0] i_wdata,
  output logic [ENTRY_W-1:0] o_rdata,
  output logic [LVL_W-1:0]   o_level,
  output logic               o_empty,
  output logic               o_full
);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   w_rd_ptr_inc;
  logic [LVL_W-1:0]   r_level;
  logic [LVL_W-1:0]   w_level_nxt;
  logic [ENTRY_W-1:0] r_head;
  logic [ENTRY_W-1:0] w_head_nxt;
  logic               r_nonempty;
  logic               r_full;
  logic               w_push;
  logic               w_pop;

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign w_pop        = i_pop & r_nonempty;
  assign w_push       = i_push & (~r_full | w_pop);
  assign w_rd_ptr_inc = r_rd_ptr + PTR_W'(1);

  // Occupancy update: +push -pop.
  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LVL_W'(1);
      2'b01:   w_level_nxt = r_level - LVL_W'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Head register: next stored entry after a pop, or the incoming word when nothing else is queued.
  always_comb begin
    w_head_nxt = r_head;
    if (w_pop) begin
      if (r_level > LVL_W'(1)) begin
        w_head_nxt = r_mem[w_rd_ptr_inc];
      end else if (w_push) begin
        w_head_nxt = i_wdata;
      end else begin
        w_head_nxt = r_head;
      end
    end else if (w_push && (r_level == LVL_W'(0))) begin
      w_head_nxt = i_wdata;
    end else begin
      w_head_nxt = r_head;
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers, occupancy, registered flags and head entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_head     <= '0;
      r_nonempty <= 1'b0;
      r_full     <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      r_level    <= w_level_nxt;
      r_head     <= w_head_nxt;
      r_nonempty <= (w_level_nxt != LVL_W'(0));
      r_full     <= (w_level_nxt == LVL_W'(DEPTH));
    end
  end

  assign o_rdata = r_head;
  assign o_level = r_level;
  assign o_empty = ~r_nonempty;
  assign o_full  = r_full;

endmodule

// File: rtl/axis_out_stream_buffer.sv
// Buffers packer words (no backpressure) and drives them onto an AXI4-Stream master.
// Also reports sticky overflow, occupancy and per-layer beat counts.
module axis_out_stream_buffer
  import axis_out_stream_buffer_pkg::*;
#(
  parameter  int unsigned C_M_AXIS_TDATA_WIDTH = DEF_TDATA_WIDTH,
  parameter  int unsigned FIFO_DEPTH           = DEF_FIFO_DEPTH,
  parameter  int unsigned CNT_WIDTH            = DEF_CNT_WIDTH,
  localparam int unsigned LVL_W                = clogb2(FIFO_DEPTH) + 32'd1,
  localparam int unsigned ENTRY_W              = C_M_AXIS_TDATA_WIDTH + 32'd1,
  localparam int unsigned STRB_W               = C_M_AXIS_TDATA_WIDTH / 32'd8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  input  logic                            in_last,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0] in_data,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                            m_axis_tlast,
  output logic [STRB_W-1:0]               m_axis_tstrb,
  output logic [LVL_W-1:0]                fifo_level,
  output logic                            overflow,
  input  logic                            clr_overflow,
  output logic                            frame_done,
  output logic [CNT_WIDTH-1:0]            frame_beats
);

  logic [ENTRY_W-1:0]   w_wdata;
  logic [ENTRY_W-1:0]   w_rdata;
  logic [LVL_W-1:0]     w_level;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_head_last;
  logic                 r_overflow;
  logic                 r_frame_done;
  logic [CNT_WIDTH-1:0] r_beat_cnt;
  logic [CNT_WIDTH-1:0] r_frame_beats;

  assign w_pop       = ~w_empty & m_axis_tready;
  assign w_push      = in_valid & (~w_full | w_pop);
  assign w_drop      = in_valid & w_full & ~w_pop;
  assign w_wdata     = {in_last, in_data};
  assign w_head_last = w_rdata[C_M_AXIS_TDATA_WIDTH];

  stream_fifo_fwft #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_level (w_level),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_overflow) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= r_overflow;
    end
  end

  // Per-layer beat counter; the tlast beat is included in the reported total.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt    <= '0;
      r_frame_beats <= '0;
      r_frame_done  <= 1'b0;
    end else begin
      r_frame_done <= w_pop & w_head_last;
      if (w_pop) begin
        if (w_head_last) begin
          r_frame_beats <= r_beat_cnt + CNT_WIDTH'(1);
          r_beat_cnt    <= '0;
        end else begin
          r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign m_axis_tvalid = ~w_empty;
  assign m_axis_tdata  = w_rdata[C_M_AXIS_TDATA_WIDTH-1:0];
  assign m_axis_tlast  = w_head_last;
  assign m_axis_tstrb  = {STRB_W{1'b1}};
  assign fifo_level    = w_level;
  assign overflow      = r_overflow;
  assign frame_done    = r_frame_done;
  assign frame_beats   = r_frame_beats;

endmodule

// File: tb/tb_axis_out_stream_buffer.sv
// Scoreboard bench for axis_out_stream_buffer: stimulus queues expected beats and
// layer totals, an independent monitor pops and compares on every transfer.
module tb_axis_out_stream_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic [3:0]  m_axis_tstrb;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic        clr_overflow = 1'b0;
  logic        frame_done;
  logic [15:0] frame_beats;

  int checks = 0;
  int errors = 0;
  int acc_beats = 0;
  int done_count = 0;
  int beat_count = 0;
  int mark;
  logic [32:0] exp_q[$];
  int          exp_frame_q[$];

  always #5 clk = ~clk;

  axis_out_stream_buffer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .in_data       (in_data),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tstrb  (m_axis_tstrb),
    .fifo_level    (fifo_level),
    .overflow      (overflow),
    .clr_overflow  (clr_overflow),
    .frame_done    (frame_done),
    .frame_beats   (frame_beats)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; acc says whether this word should enter the FIFO.
  task automatic drive(input logic v, input logic l, input logic [31:0] d,
                       input logic rdy, input logic acc, input logic clr);
    in_valid      = v;
    in_last       = l;
    in_data       = d;
    m_axis_tready = rdy;
    clr_overflow  = clr;
    if (v && acc) begin
      exp_q.push_back({l, d});
      acc_beats++;
      if (l) begin
        exp_frame_q.push_back(acc_beats);
        acc_beats = 0;
      end
    end
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    in_last      = 1'b0;
    clr_overflow = 1'b0;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 32'h0, rdy, 1'b0, 1'b0);
    end
  endtask

  // Monitor: compares transfers, stall stability and frame_done/frame_beats.
  initial begin
    logic        prev_stall;
    logic        done_pending;
    logic [32:0] prev_word;
    prev_stall   = 1'b0;
    done_pending = 1'b0;
    prev_word    = 33'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall   = 1'b0;
        done_pending = 1'b0;
      end else begin
        check("frame_done", 64'(frame_done), 64'(done_pending));
        if (frame_done) begin
          done_count++;
          if (exp_frame_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_unexpected: got frame_beats=%0d, expected no frame", frame_beats);
          end else begin
            check("frame_beats", 64'(frame_beats), 64'(exp_frame_q.pop_front()));
          end
        end
        if (prev_stall) begin
          check("stall_tvalid", 64'(m_axis_tvalid), 64'(1));
          check("stall_data", 64'({m_axis_tlast, m_axis_tdata}), 64'(prev_word));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          beat_count++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL beat_unexpected: got 0x%0h, expected no beat", {m_axis_tlast, m_axis_tdata});
          end else begin
            check("beat", 64'({m_axis_tlast, m_axis_tdata}), 64'(exp_q.pop_front()));
          end
        end
        done_pending = m_axis_tvalid & m_axis_tready & m_axis_tlast;
        prev_stall   = m_axis_tvalid & ~m_axis_tready;
        prev_word    = {m_axis_tlast, m_axis_tdata};
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("rst_tdata", 64'(m_axis_tdata), 64'(0));
    check("rst_tlast", 64'(m_axis_tlast), 64'(0));
    check("rst_tstrb", 64'(m_axis_tstrb), 64'(4'hF));
    check("rst_level", 64'(fifo_level), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    check("rst_frame_done", 64'(frame_done), 64'(0));
    check("rst_frame_beats", 64'(frame_beats), 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Five-word layer with continuous tready
    drive(1'b1, 1'b0, 32'h1, 1'b1, 1'b1, 1'b0);
    check("t1_latency_valid", 64'(m_axis_tvalid), 64'(1));
    check("t1_latency_data", 64'(m_axis_tdata), 64'(32'h1));
    for (int k = 2; k <= 5; k++) begin
      drive(1'b1, (k == 5), 32'(k), 1'b1, 1'b1, 1'b0);
    end
    idle(4, 1'b1);
    check("t1_frame_beats", 64'(frame_beats), 64'(5));
    check("t1_done_count", 64'(done_count), 64'(1));
    check("t1_level", 64'(fifo_level), 64'(0));

    // Fill, overflow, clear, push-with-pop while full, clear/drop race
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 32'h100 + 32'(i), 1'b0, 1'b1, 1'b0);
    end
    check("t2_full_level", 64'(fifo_level), 64'(16));
    check("t2_full_ovf", 64'(overflow), 64'(0));
    check("t2_full_head", 64'(m_axis_tdata), 64'(32'h100));
    drive(1'b1, 1'b0, 32'h110, 1'b0, 1'b0, 1'b0);
    check("t2_drop_ovf", 64'(overflow), 64'(1));
    check("t2_drop_level", 64'(fifo_level), 64'(16));
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check("t2_clr_ovf", 64'(overflow), 64'(0));
    drive(1'b1, 1'b1, 32'h111, 1'b1, 1'b1, 1'b0);
    check("t2_pushpop_level", 64'(fifo_level), 64'(16));
    check("t2_pushpop_ovf", 64'(overflow), 64'(0));
    drive(1'b1, 1'b0, 32'h112, 1'b0, 1'b0, 1'b0);
    check("t2_drop2_ovf", 64'(overflow), 64'(1));
    drive(1'b1, 1'b0, 32'h113, 1'b0, 1'b0, 1'b1);
    check("t2_race_ovf", 64'(overflow), 64'(1));
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check("t2_clr2_ovf", 64'(overflow), 64'(0));
    mark = beat_count;
    idle(20, 1'b1);
    check("t2_drained", 64'(beat_count - mark), 64'(16));
    check("t2_empty_level", 64'(fifo_level), 64'(0));
    check("t2_empty_valid", 64'(m_axis_tvalid), 64'(0));
    check("t2_frame_beats", 64'(frame_beats), 64'(17));

    // 40-word layer with tready toggling every cycle
    mark = done_count;
    for (int i = 0; i < 80; i++) begin
      drive((i % 2 == 0), (i / 2 == 39), 32'h4000_0000 + 32'(i / 2), (i % 2 == 0), 1'b1, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 32'h0, (i % 2 == 0), 1'b0, 1'b0);
    end
    check("t3_frame_beats", 64'(frame_beats), 64'(40));
    check("t3_done_count", 64'(done_count - mark), 64'(1));
    check("t3_level", 64'(fifo_level), 64'(0));

    // Reset with seven words buffered
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, 32'h500 + 32'(i), 1'b0, 1'b1, 1'b0);
    end
    check("t4_pre_valid", 64'(m_axis_tvalid), 64'(1));
    check("t4_pre_level", 64'(fifo_level), 64'(7));
    rst_n = 1'b0;
    exp_q.delete();
    exp_frame_q.delete();
    acc_beats = 0;
    #1;
    check("t4_rst_valid", 64'(m_axis_tvalid), 64'(0));
    check("t4_rst_level", 64'(fifo_level), 64'(0));
    check("t4_rst_ovf", 64'(overflow), 64'(0));
    check("t4_rst_frame_beats", 64'(frame_beats), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 32'h600, 1'b0, 1'b1, 1'b0);
    check("t4_new_valid", 64'(m_axis_tvalid), 64'(1));
    check("t4_new_data", 64'(m_axis_tdata), 64'(32'h600));
    check("t4_new_last", 64'(m_axis_tlast), 64'(1));
    check("t4_new_level", 64'(fifo_level), 64'(1));
    idle(3, 1'b1);
    check("t4_frame_beats", 64'(frame_beats), 64'(1));

    // Consecutive single-word layers
    mark = done_count;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 32'h700 + 32'(k), 1'b1, 1'b1, 1'b0);
    end
    idle(4, 1'b1);
    check("t5_done_count", 64'(done_count - mark), 64'(3));
    check("t5_frame_beats", 64'(frame_beats), 64'(1));

    check("end_beats_left", 64'(exp_q.size()), 64'(0));
    check("end_frames_left", 64'(exp_frame_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
